// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register bank: default geometry, address and
// data word types for the default geometry, the hard-wired zero address and
// a helper that decides whether an address is masked by the zero register.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]    addr_t;
    typedef logic [DEF_WIDTH-1:0] word_t;

    localparam int unsigned ZERO_ADDR = 32'd0;

    // True when the zero register is enabled and the address selects it.
    function automatic logic zero_masked(input logic zero_reg, input int unsigned addr);
        return zero_reg && (addr == ZERO_ADDR);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One synchronous read port of the register bank. Selects an entry from the
// flattened storage, applies the zero-register mask and (with the build
// macro REGFILE_BYPASS_EN defined) forwards a same-cycle write, then holds
// the result in output registers that only load while re_i is high.
//
// Ports:
//   clk_i       clock, rising edge
//   reset_i     synchronous active-high reset
//   re_i        read enable; 0 holds the outputs
//   raddr_i     read address
//   mem_i       storage array, entry k at mem_i[k]
//   written_i   per-entry "written since reset" flags
//   we_i, waddr_i, wdata_i   write port, present only with REGFILE_BYPASS_EN
//   rdata_o     registered read data
//   written_o   registered written flag of the entry read
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        re_i,
    input  logic [AW-1:0]               raddr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
    input  logic [DEPTH-1:0]            written_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                        we_i,
    input  logic [AW-1:0]               waddr_i,
    input  logic [WIDTH-1:0]            wdata_i,
`endif
    output logic [WIDTH-1:0]            rdata_o,
    output logic                        written_o
);

    logic [WIDTH-1:0] rdata_d;
    logic             written_d;
    logic [WIDTH-1:0] rdata_q;
    logic             written_q;

    // Next read value: zero mask wins, then write forwarding, then storage.
    always_comb begin
        rdata_d   = mem_i[raddr_i];
        written_d = written_i[raddr_i];
        if (zero_masked(ZERO_REG, 32'(raddr_i))) begin
            rdata_d   = '0;
            written_d = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (we_i && (waddr_i == raddr_i)) begin
            rdata_d   = wdata_i;
            written_d = 1'b1;
        end
`endif
        else begin
            rdata_d   = mem_i[raddr_i];
            written_d = written_i[raddr_i];
        end
    end

    // Output hold registers: load on re_i, otherwise keep the last read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q   <= '0;
            written_q <= 1'b0;
        end else if (re_i) begin
            rdata_q   <= rdata_d;
            written_q <= written_d;
        end else begin
            rdata_q   <= rdata_q;
            written_q <= written_q;
        end
    end

    assign rdata_o   = rdata_q;
    assign written_o = written_q;

endmodule

// File: rtl/regfile_bank.sv
// ---------------------------------------------------------------------------
// regfile_bank
// Parametrised register bank with one write port and two independent
// registered read ports sharing a read enable. Owns the storage, the
// per-entry written flags and the write logic; each read port is a
// regfile_read_port instance.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writes to a
// colliding read (write-through). Undefined, a colliding read returns the
// pre-write contents.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset, priority over we/re
//   we, waddr, wdata          write port
//   re                        read enable for both ports (0 holds outputs)
//   raddr_a, raddr_b          read addresses
//   rdata_a, rdata_b          registered read data
//   rvalid                    1 the cycle after an accepted read
//   written_a, written_b      registered written flag of the entry read
// ---------------------------------------------------------------------------
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid,
    output logic             written_a,
    output logic             written_b
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0]            written_q;
    logic                        rvalid_q;
    logic                        wr_en_s;

    // Writes to the hard-wired zero entry are dropped.
    always_comb begin
        wr_en_s = 1'b0;
        if (we && !zero_masked(ZERO_REG, 32'(waddr))) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage and written flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q     <= '0;
            written_q <= '0;
        end else if (wr_en_s) begin
            mem_q[waddr]     <= wdata;
            written_q[waddr] <= 1'b1;
        end else begin
            mem_q     <= mem_q;
            written_q <= written_q;
        end
    end

    // Read-valid flag follows the read enable by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re;
        end
    end

    assign rvalid = rvalid_q;

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .clk_i     (clk),
        .reset_i   (reset),
        .re_i      (re),
        .raddr_i   (raddr_a),
        .mem_i     (mem_q),
        .written_i (written_q),
`ifdef REGFILE_BYPASS_EN
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
`endif
        .rdata_o   (rdata_a),
        .written_o (written_a)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .clk_i     (clk),
        .reset_i   (reset),
        .re_i      (re),
        .raddr_i   (raddr_b),
        .mem_i     (mem_q),
        .written_i (written_q),
`ifdef REGFILE_BYPASS_EN
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
`endif
        .rdata_o   (rdata_b),
        .written_o (written_b)
    );

endmodule

// File: tb/tb_regfile_bank.sv
// ---------------------------------------------------------------------------
// tb_regfile_bank
// Directed scenarios followed by random traffic on regfile_bank (default
// parameters), checked against an array-based model of the bank.
// ---------------------------------------------------------------------------
module tb_regfile_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             rvalid;
    logic             written_a;
    logic             written_b;

    regfile_bank dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .rvalid    (rvalid),
        .written_a (written_a),
        .written_b (written_b)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_wr  [DEPTH];
    logic [WIDTH-1:0] e_rdata_a, e_rdata_b;
    logic             e_wr_a, e_wr_b, e_rvalid;

    int checks   = 0;
    int failures = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // What a read of address a returns this cycle: {written, data}.
    function automatic logic [32:0] model_read(input int a, input bit w, input int wa,
                                               input logic [31:0] wd);
        if (a == 0) return 33'd0;
        if (BYPASS && w && (wa == a)) return {1'b1, wd};
        return {m_wr[a], m_mem[a]};
    endfunction

    // Drive one cycle, advance the model across the edge, compare all outputs.
    task automatic cycle(input bit rst, input bit w, input int wa, input logic [31:0] wd,
                         input bit r, input int ra, input int rb);
        logic [32:0] va, vb;
        reset = rst; we = w; waddr = AW'(wa); wdata = wd;
        re = r; raddr_a = AW'(ra); raddr_b = AW'(rb);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_wr[i]  = 1'b0;
            end
            e_rdata_a = '0; e_rdata_b = '0; e_wr_a = 1'b0; e_wr_b = 1'b0; e_rvalid = 1'b0;
        end else begin
            if (r) begin
                va = model_read(ra, w, wa, wd);
                vb = model_read(rb, w, wa, wd);
                e_rdata_a = va[31:0]; e_wr_a = va[32];
                e_rdata_b = vb[31:0]; e_wr_b = vb[32];
            end
            e_rvalid = r;
            if (w && wa != 0) begin
                m_mem[wa] = wd;
                m_wr[wa]  = 1'b1;
            end
        end
        #1;
        check_eq("rdata_a",   rdata_a,          e_rdata_a);
        check_eq("rdata_b",   rdata_b,          e_rdata_b);
        check_eq("written_a", 32'(written_a),   32'(e_wr_a));
        check_eq("written_b", 32'(written_b),   32'(e_wr_b));
        check_eq("rvalid",    32'(rvalid),      32'(e_rvalid));
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re = 1'b0; raddr_a = '0; raddr_b = '0;

        // Reset, then read two never-written entries.
        cycle(1, 0, 0, 32'h0, 0, 0, 0);
        check_eq("rst_rdata_a", rdata_a, 32'h0);
        check_eq("rst_rvalid",  32'(rvalid), 32'h0);
        cycle(0, 0, 0, 32'h0, 1, 5, 9);
        check_eq("rd_after_rst_a",  rdata_a, 32'h0);
        check_eq("rd_after_rst_wa", 32'(written_a), 32'h0);
        check_eq("rd_after_rst_v",  32'(rvalid), 32'h1);

        // Write then read.
        cycle(0, 1, 3, 32'h0000_002A, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 1, 3, 3);
        check_eq("wr_rd_a",  rdata_a, 32'h2A);
        check_eq("wr_rd_wa", 32'(written_a), 32'h1);
        check_eq("wr_rd_b",  rdata_b, 32'h2A);

        // Zero register discards writes.
        cycle(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 1, 0, 0);
        check_eq("zero_rd",  rdata_a, 32'h0);
        check_eq("zero_wr",  32'(written_a), 32'h0);

        // Hold while re=0, then reload.
        cycle(0, 0, 0, 32'h0, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 3, 32'h55, 0, 3, 0);
            check_eq("hold_rd", rdata_a, 32'h2A);
            check_eq("hold_v",  32'(rvalid), 32'h0);
        end
        cycle(0, 0, 0, 32'h0, 1, 3, 0);
        check_eq("reload_rd", rdata_a, 32'h55);

        // Write/read collision.
        cycle(0, 1, 7, 32'h11, 0, 0, 0);
        cycle(0, 1, 7, 32'h22, 1, 7, 7);
        check_eq("collide_a", rdata_a, BYPASS ? 32'h22 : 32'h11);
        cycle(0, 0, 0, 32'h0, 1, 7, 0);
        check_eq("collide_later", rdata_a, 32'h22);

        // Reset priority over a simultaneous write.
        cycle(0, 1, 4, 32'h99, 0, 0, 0);
        cycle(1, 1, 4, 32'h77, 1, 4, 4);
        check_eq("rstpri_rd", rdata_a, 32'h0);
        check_eq("rstpri_v",  32'(rvalid), 32'h0);
        cycle(0, 0, 0, 32'h0, 1, 4, 4);
        check_eq("rstpri_entry", rdata_a, 32'h0);
        check_eq("rstpri_wr",    32'(written_b), 32'h0);

        // Random traffic with occasional reset and forced collisions.
        for (int n = 0; n < 600; n++) begin
            bit rst_r, w_r, r_r;
            int wa_r, ra_r, rb_r;
            rst_r = ($urandom_range(99, 0) < 2);
            w_r   = ($urandom_range(99, 0) < 55);
            r_r   = ($urandom_range(99, 0) < 70);
            wa_r  = int'($urandom_range(DEPTH-1, 0));
            ra_r  = int'($urandom_range(DEPTH-1, 0));
            rb_r  = int'($urandom_range(DEPTH-1, 0));
            if ($urandom_range(99, 0) < 20) ra_r = wa_r;
            if ($urandom_range(99, 0) < 10) rb_r = wa_r;
            cycle(rst_r, w_r, wa_r, 32'($urandom), r_r, ra_r, rb_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised multi-entry register bank; the multi-word successor to the single load-enabled register.
- One write port and two independent synchronous read ports, with registered outputs and a stall/hold control.
- Sits between control FSM and ALU datapath; feeds GCD/ALU operands, receives results.

Parameters:
- WIDTH, 32, data width of each entry and each read/write data port.
- DEPTH, 16, number of entries; any power of two, 2 to 64.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded; when 0 entry 0 is ordinary.
- Localparam AW = $clog2(DEPTH), address width; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- re  input  1  read enable, both ports; 0 holds rdata_a/rdata_b, like a deasserted load enable.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rdata_b  output  WIDTH  registered read data, port B.
- rvalid  output  1  high the cycle after an accepted read (re=1).
- written_a  output  1  registered; 1 if entry read on A has been written since reset.
- written_b  output  1  same for port B.

Behaviour:
- Reset is sampled only at a clk rising edge; there is no asynchronous path. Reset has priority over we/re in the same cycle.
- On reset:
  - All entries cleared to 0 and all per-entry written bits cleared.
  - rdata_a, rdata_b, rvalid, written_a and written_b all go to 0.
- Write: on an edge with we=1 and reset=0, entry[waddr] <= wdata and written[waddr] <= 1.
  - If ZERO_REG=1 and waddr=0, the write is discarded and written[0] stays 0.
- Read with re=1 at edge N:
  - rdata_a <= entry[raddr_a] and written_a <= written[raddr_a]; same for port B.
  - rvalid <= 1. Latency is exactly 1 cycle; values are visible after edge N.
- Read with re=0:
  - rdata_*, written_* hold their previous values.
  - rvalid <= 0.
- ZERO_REG=1 and raddr_x=0: rdata_x <= 0 and written_x <= 0, regardless of storage.
- Both ports may read the same address; both see identical data.
- Simultaneous write and read of the same address, in the same cycle: without the optional feature, the read returns the OLD value (pre-write contents and pre-write written bit).
- Out-of-range address: not possible because DEPTH is a power of two, so no wrap logic is needed.
- Reset asserted mid-stream: any write or read presented in that cycle is dropped; the next cycle behaves as post-reset.
- Storage holds its value indefinitely without we; there is no implicit clear other than reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A same-cycle write/read collision (we=1, re=1, waddr==raddr_x, and not ZERO_REG-masked) returns wdata on rdata_x and 1 on written_x.
  - This gives write-through, read-after-write in one cycle.
- Undefined: the old-value behaviour above; no bypass comparators are synthesised.

Decomposition:
- Shared package regfile_pkg:
  - Default WIDTH/DEPTH constants.
  - Typedef for the address type and the data word.
  - Constant ZERO_ADDR = 0.
- One natural sub-module: regfile_read_port, instantiated twice (A, B).
  - Contains the address mux, the ZERO_REG mask, the optional bypass compare and the output hold register.
  - Takes the storage array and written vector as inputs.
- The top module owns the storage, the written vector and the write logic.

Test Plan:
- Reset then read: assert reset 1 cycle; re=1, raddr_a=5, raddr_b=9 -> next cycle rdata_a=0, rdata_b=0, written_a=0, written_b=0, rvalid=1.
- Write then read: we=1, waddr=3, wdata=0x0000_002A; next cycle re=1, raddr_a=3 -> following cycle rdata_a=0x2A, written_a=1.
- Zero register (ZERO_REG=1): we=1, waddr=0, wdata=0xFFFF_FFFF; then read addr 0 -> rdata=0, written=0.
- Hold: load rdata_a=0x2A; then re=0 for 3 cycles while writing 0x55 to entry 3 -> rdata_a stays 0x2A, rvalid=0.
  - Then re=1 -> rdata_a=0x55.
- Collision: entry 7 holds 0x11; same cycle we=1, waddr=7, wdata=0x22, re=1, raddr_a=7 -> rdata_a=0x11 without REGFILE_BYPASS_EN, 0x22 with it.
  - In both cases a later read returns 0x22.
- Reset priority: entry 4 holds 0x99; same cycle reset=1, we=1, waddr=4, wdata=0x77 -> after the edge all outputs 0; a read of 4 returns 0, written=0.
